// File: rtl/axi_burst_ram_pkg.sv
// Shared definitions for axi_burst_ram: burst/response encodings, FSM states
// and the per-beat address-advance rule.
// Optional feature macro: AXI_BURST_RAM_WRAP_EN (enables WRAP bursts).
package axi_burst_ram_pkg;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] RESP_OKAY = 2'b00;

`ifdef AXI_BURST_RAM_WRAP_EN
  localparam bit WRAP_EN = 1'b1;
`else
  localparam bit WRAP_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    W_IDLE  = 2'd0,
    W_BURST = 2'd1,
    W_RESP  = 2'd2
  } wr_state_t;

  typedef enum logic [0:0] {
    R_IDLE  = 1'b0,
    R_BURST = 1'b1
  } rd_state_t;

  // Address of the beat following 'addr'. Computed at 64 bits; callers truncate.
  // WRAP keeps the address inside an aligned (len+1)*2^size block; unsupported
  // WRAP lengths, reserved bursts and disabled WRAP all fall back to INCR.
  function automatic logic [63:0] burst_next_addr(input logic [63:0] addr,
                                                  input logic [2:0]  size,
                                                  input logic [1:0]  burst,
                                                  input logic [31:0] len);
    logic [63:0] step;
    logic [63:0] span;
    logic [63:0] nxt;
    step = 64'd1 << size;
    span = (64'(len) + 64'd1) << size;
    nxt  = addr + step;
    if (burst == BURST_FIXED) begin
      nxt = addr;
    end else if (WRAP_EN && burst == BURST_WRAP &&
                 (len == 32'd1 || len == 32'd3 || len == 32'd7 || len == 32'd15)) begin
      nxt = (addr & ~(span - 64'd1)) | ((addr + step) & (span - 64'd1));
    end
    return nxt;
  endfunction

endpackage

// File: rtl/axi_burst_ram_mem.sv
// Simple dual-port RAM: byte-enabled write port, registered read port.
// A read and write of the same word in one cycle returns the old contents.
module axi_burst_ram_mem #(
  parameter int DATA_WIDTH = 32,
  parameter int WORD_AW    = 14
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    we,
  input  logic [WORD_AW-1:0]      waddr,
  input  logic [DATA_WIDTH/8-1:0] wstrb,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic                    re,
  input  logic [WORD_AW-1:0]      raddr,
  output logic [DATA_WIDTH-1:0]   rdata
);

  localparam int unsigned NBYTES = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] mem [2**WORD_AW];

  // Byte-enabled write; storage is never reset
  always_ff @(posedge clk) begin
    if (we) begin
      for (int unsigned i = 0; i < NBYTES; i++) begin
        if (wstrb[i]) mem[waddr][i*8 +: 8] <= wdata[i*8 +: 8];
      end
    end
  end

  // Registered read; output holds when re is low
  always_ff @(posedge clk) begin
    if (rst)     rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/axi_burst_ram.sv
// AXI4 slave RAM with independent write (AW/W/B) and read (AR/R) engines.
// FIXED and INCR bursts; WRAP when AXI_BURST_RAM_WRAP_EN is defined.
module axi_burst_ram #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16,
  parameter int STRB_WIDTH = DATA_WIDTH / 8,
  parameter int ID_WIDTH   = 8,
  parameter int LEN_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ID_WIDTH-1:0]   s_axi_awid,
  input  logic [ADDR_WIDTH-1:0] s_axi_awaddr,
  input  logic [LEN_WIDTH-1:0]  s_axi_awlen,
  input  logic [2:0]            s_axi_awsize,
  input  logic [1:0]            s_axi_awburst,
  input  logic                  s_axi_awlock,
  input  logic [3:0]            s_axi_awcache,
  input  logic [2:0]            s_axi_awprot,
  input  logic [3:0]            s_axi_awqos,
  input  logic                  s_axi_awvalid,
  output logic                  s_axi_awready,
  input  logic [DATA_WIDTH-1:0] s_axi_wdata,
  input  logic [STRB_WIDTH-1:0] s_axi_wstrb,
  input  logic                  s_axi_wlast,
  input  logic                  s_axi_wvalid,
  output logic                  s_axi_wready,
  output logic [ID_WIDTH-1:0]   s_axi_bid,
  output logic [1:0]            s_axi_bresp,
  output logic                  s_axi_bvalid,
  input  logic                  s_axi_bready,
  input  logic [ID_WIDTH-1:0]   s_axi_arid,
  input  logic [ADDR_WIDTH-1:0] s_axi_araddr,
  input  logic [LEN_WIDTH-1:0]  s_axi_arlen,
  input  logic [2:0]            s_axi_arsize,
  input  logic [1:0]            s_axi_arburst,
  input  logic                  s_axi_arlock,
  input  logic [3:0]            s_axi_arcache,
  input  logic [2:0]            s_axi_arprot,
  input  logic [3:0]            s_axi_arqos,
  input  logic                  s_axi_arvalid,
  output logic                  s_axi_arready,
  output logic [ID_WIDTH-1:0]   s_axi_rid,
  output logic [DATA_WIDTH-1:0] s_axi_rdata,
  output logic [1:0]            s_axi_rresp,
  output logic                  s_axi_rlast,
  output logic                  s_axi_rvalid,
  input  logic                  s_axi_rready
);

  import axi_burst_ram_pkg::*;

  localparam int unsigned OFFS    = $clog2(STRB_WIDTH);
  localparam int unsigned WORD_AW = ADDR_WIDTH - OFFS;

  // Sideband inputs carry no meaning for a plain RAM
  logic unused_inputs;
  assign unused_inputs = ^{s_axi_awlock, s_axi_awcache, s_axi_awprot, s_axi_awqos,
                           s_axi_arlock, s_axi_arcache, s_axi_arprot, s_axi_arqos,
                           s_axi_wlast};

  assign s_axi_bresp = RESP_OKAY;
  assign s_axi_rresp = RESP_OKAY;

  // ---------------- write engine ----------------
  wr_state_t             wr_state;
  logic [ID_WIDTH-1:0]   w_id;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [LEN_WIDTH-1:0]  w_len;
  logic [LEN_WIDTH-1:0]  w_cnt;
  logic [2:0]            w_size;
  logic [1:0]            w_burst;
  logic [ADDR_WIDTH-1:0] w_next;
  logic                  w_beat;

  assign w_next = ADDR_WIDTH'(burst_next_addr(64'(w_addr), w_size, w_burst, 32'(w_len)));
  assign w_beat = s_axi_wvalid && s_axi_wready;

  // Write FSM: accept AW, count W beats, then hold B until accepted
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_state      <= W_IDLE;
      s_axi_awready <= 1'b1;
      s_axi_wready  <= 1'b0;
      s_axi_bvalid  <= 1'b0;
      s_axi_bid     <= '0;
      w_id          <= '0;
      w_addr        <= '0;
      w_len         <= '0;
      w_cnt         <= '0;
      w_size        <= '0;
      w_burst       <= '0;
    end else begin
      unique case (wr_state)
        W_IDLE: if (s_axi_awvalid && s_axi_awready) begin
          w_id          <= s_axi_awid;
          w_addr        <= s_axi_awaddr;
          w_len         <= s_axi_awlen;
          w_cnt         <= s_axi_awlen;
          w_size        <= s_axi_awsize;
          w_burst       <= s_axi_awburst;
          s_axi_awready <= 1'b0;
          s_axi_wready  <= 1'b1;
          wr_state      <= W_BURST;
        end
        W_BURST: if (w_beat) begin
          w_addr <= w_next;
          if (w_cnt == '0) begin
            s_axi_wready <= 1'b0;
            s_axi_bvalid <= 1'b1;
            s_axi_bid    <= w_id;
            wr_state     <= W_RESP;
          end else begin
            w_cnt <= w_cnt - 1'b1;
          end
        end
        W_RESP: if (s_axi_bready) begin
          s_axi_bvalid  <= 1'b0;
          s_axi_awready <= 1'b1;
          wr_state      <= W_IDLE;
        end
        default: wr_state <= W_IDLE;
      endcase
    end
  end

  // ---------------- read engine ----------------
  rd_state_t             rd_state;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [LEN_WIDTH-1:0]  r_len;
  logic [LEN_WIDTH-1:0]  r_cnt;
  logic [2:0]            r_size;
  logic [1:0]            r_burst;
  logic [ADDR_WIDTH-1:0] r_next;
  logic                  ar_hs;
  logic                  r_beat;
  logic                  mem_re;
  logic [WORD_AW-1:0]    mem_raddr;

  assign r_next = ADDR_WIDTH'(burst_next_addr(64'(r_addr), r_size, r_burst, 32'(r_len)));
  assign ar_hs  = s_axi_arvalid && s_axi_arready;
  assign r_beat = s_axi_rvalid && s_axi_rready;

  // The RAM read is issued one cycle ahead of the beat it feeds: from araddr on
  // the AR handshake, from the advanced address when a non-final beat is taken.
  // With no read issued the RAM output register holds, keeping rdata stable.
  assign mem_re    = ar_hs || (r_beat && !s_axi_rlast);
  assign mem_raddr = ar_hs ? s_axi_araddr[ADDR_WIDTH-1:OFFS] : r_next[ADDR_WIDTH-1:OFFS];

  // Read FSM: accept AR, stream len+1 beats under rready flow control
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_state      <= R_IDLE;
      s_axi_arready <= 1'b1;
      s_axi_rvalid  <= 1'b0;
      s_axi_rlast   <= 1'b0;
      s_axi_rid     <= '0;
      r_addr        <= '0;
      r_len         <= '0;
      r_cnt         <= '0;
      r_size        <= '0;
      r_burst       <= '0;
    end else begin
      unique case (rd_state)
        R_IDLE: if (ar_hs) begin
          r_addr        <= s_axi_araddr;
          r_len         <= s_axi_arlen;
          r_cnt         <= s_axi_arlen;
          r_size        <= s_axi_arsize;
          r_burst       <= s_axi_arburst;
          s_axi_rid     <= s_axi_arid;
          s_axi_rvalid  <= 1'b1;
          s_axi_rlast   <= (s_axi_arlen == '0);
          s_axi_arready <= 1'b0;
          rd_state      <= R_BURST;
        end
        R_BURST: if (r_beat) begin
          if (s_axi_rlast) begin
            s_axi_rvalid  <= 1'b0;
            s_axi_rlast   <= 1'b0;
            s_axi_arready <= 1'b1;
            rd_state      <= R_IDLE;
          end else begin
            r_addr      <= r_next;
            r_cnt       <= r_cnt - 1'b1;
            s_axi_rlast <= (r_cnt == LEN_WIDTH'(1));
          end
        end
        default: rd_state <= R_IDLE;
      endcase
    end
  end

  axi_burst_ram_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .WORD_AW    (WORD_AW)
  ) u_mem (
    .clk   (clk),
    .rst   (rst),
    .we    (w_beat),
    .waddr (w_addr[ADDR_WIDTH-1:OFFS]),
    .wstrb (s_axi_wstrb),
    .wdata (s_axi_wdata),
    .re    (mem_re),
    .raddr (mem_raddr),
    .rdata (s_axi_rdata)
  );

endmodule

// File: tb/tb_axi_burst_ram.sv
// Self-checking bench for axi_burst_ram: directed scenarios plus randomized
// bursts against a byte-level reference memory of the low 1 KiB.
module tb_axi_burst_ram;

`ifdef AXI_BURST_RAM_WRAP_EN
  localparam bit WRAP_EN = 1'b1;
`else
  localparam bit WRAP_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  s_axi_awid = '0;
  logic [15:0] s_axi_awaddr = '0;
  logic [7:0]  s_axi_awlen = '0;
  logic [2:0]  s_axi_awsize = 3'd2;
  logic [1:0]  s_axi_awburst = 2'b01;
  logic        s_axi_awvalid = 1'b0;
  logic        s_axi_awready;
  logic [31:0] s_axi_wdata = '0;
  logic [3:0]  s_axi_wstrb = '0;
  logic        s_axi_wlast = 1'b0;
  logic        s_axi_wvalid = 1'b0;
  logic        s_axi_wready;
  logic [7:0]  s_axi_bid;
  logic [1:0]  s_axi_bresp;
  logic        s_axi_bvalid;
  logic        s_axi_bready = 1'b0;
  logic [7:0]  s_axi_arid = '0;
  logic [15:0] s_axi_araddr = '0;
  logic [7:0]  s_axi_arlen = '0;
  logic [2:0]  s_axi_arsize = 3'd2;
  logic [1:0]  s_axi_arburst = 2'b01;
  logic        s_axi_arvalid = 1'b0;
  logic        s_axi_arready;
  logic [7:0]  s_axi_rid;
  logic [31:0] s_axi_rdata;
  logic [1:0]  s_axi_rresp;
  logic        s_axi_rlast;
  logic        s_axi_rvalid;
  logic        s_axi_rready = 1'b0;

  always #5 clk = ~clk;

  axi_burst_ram #(
    .DATA_WIDTH (32),
    .ADDR_WIDTH (16),
    .ID_WIDTH   (8),
    .LEN_WIDTH  (8)
  ) dut (
    .clk(clk), .rst(rst),
    .s_axi_awid(s_axi_awid), .s_axi_awaddr(s_axi_awaddr), .s_axi_awlen(s_axi_awlen),
    .s_axi_awsize(s_axi_awsize), .s_axi_awburst(s_axi_awburst), .s_axi_awlock(1'b0),
    .s_axi_awcache(4'h0), .s_axi_awprot(3'h0), .s_axi_awqos(4'h0),
    .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wlast(s_axi_wlast),
    .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
    .s_axi_bid(s_axi_bid), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
    .s_axi_bready(s_axi_bready),
    .s_axi_arid(s_axi_arid), .s_axi_araddr(s_axi_araddr), .s_axi_arlen(s_axi_arlen),
    .s_axi_arsize(s_axi_arsize), .s_axi_arburst(s_axi_arburst), .s_axi_arlock(1'b0),
    .s_axi_arcache(4'h0), .s_axi_arprot(3'h0), .s_axi_arqos(4'h0),
    .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
    .s_axi_rid(s_axi_rid), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
    .s_axi_rlast(s_axi_rlast), .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready)
  );

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  logic [31:0] ref_mem [256];
  logic [31:0] wbuf [256];
  logic [3:0]  sbuf [256];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Byte address of beat i, straight from the burst-type definitions
  function automatic int unsigned beat_addr(input int unsigned addr, input int unsigned len,
                                            input int unsigned size, input logic [1:0] burst,
                                            input int unsigned i);
    int unsigned bytes = 1 << size;
    int unsigned block;
    int unsigned base;
    if (burst == 2'b00) return addr;
    if (WRAP_EN && burst == 2'b10 && (len == 1 || len == 3 || len == 7 || len == 15)) begin
      block = (len + 1) * bytes;
      base  = (addr / block) * block;
      return base + ((addr - base) + i * bytes) % block;
    end
    return addr + i * bytes;
  endfunction

  task automatic model_write(input int unsigned addr, input logic [31:0] data, input logic [3:0] strb);
    int unsigned w = (addr >> 2) & 255;
    for (int b = 0; b < 4; b++) if (strb[b]) ref_mem[w][b*8 +: 8] = data[b*8 +: 8];
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full write transaction using wbuf/sbuf; optional W gaps and B delay
  task automatic do_write(input int unsigned addr, input int unsigned len, input int unsigned size,
                          input logic [1:0] burst, input logic [7:0] id,
                          input int unsigned bdelay, input bit gaps);
    int unsigned t = 0;
    while (!s_axi_awready && t < 50) begin tick(); t++; end
    check("awready_wait", s_axi_awready, 1'b1);
    s_axi_awid = id; s_axi_awaddr = 16'(addr); s_axi_awlen = 8'(len);
    s_axi_awsize = 3'(size); s_axi_awburst = burst; s_axi_awvalid = 1'b1;
    tick();
    s_axi_awvalid = 1'b0;
    check("wready_after_aw", s_axi_wready, 1'b1);
    for (int unsigned i = 0; i <= len; i++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin s_axi_wvalid = 1'b0; tick(); end
      s_axi_wdata = wbuf[i]; s_axi_wstrb = sbuf[i]; s_axi_wlast = (i == len); s_axi_wvalid = 1'b1;
      t = 0;
      while (!s_axi_wready && t < 20) begin tick(); t++; end
      if (!s_axi_wready) begin check("wready_beat", s_axi_wready, 1'b1); break; end
      tick();
      model_write(beat_addr(addr, len, size, burst, i), wbuf[i], sbuf[i]);
    end
    s_axi_wvalid = 1'b0; s_axi_wlast = 1'b0;
    check("bvalid_after_w", s_axi_bvalid, 1'b1);
    check("wready_after_last", s_axi_wready, 1'b0);
    check("bid", s_axi_bid, id);
    check("bresp", s_axi_bresp, 2'b00);
    repeat (bdelay) begin
      tick();
      check("bvalid_held", s_axi_bvalid, 1'b1);
      check("awready_busy", s_axi_awready, 1'b0);
    end
    s_axi_bready = 1'b1;
    tick();
    s_axi_bready = 1'b0;
    check("bvalid_clear", s_axi_bvalid, 1'b0);
    check("awready_back", s_axi_awready, 1'b1);
  endtask

  // Full read transaction; mode 0 rready=1, 1 pattern 1,0,0, 2 random
  task automatic do_read(input int unsigned addr, input int unsigned len, input int unsigned size,
                         input logic [1:0] burst, input logic [7:0] id, input int unsigned mode);
    int unsigned t = 0;
    int unsigned i = 0;
    int unsigned cyc = 0;
    bit r;
    while (!s_axi_arready && t < 50) begin tick(); t++; end
    check("arready_wait", s_axi_arready, 1'b1);
    s_axi_arid = id; s_axi_araddr = 16'(addr); s_axi_arlen = 8'(len);
    s_axi_arsize = 3'(size); s_axi_arburst = burst; s_axi_arvalid = 1'b1;
    tick();
    s_axi_arvalid = 1'b0;
    while (i <= len && cyc < 2000) begin
      check("rvalid", s_axi_rvalid, 1'b1);
      if (!s_axi_rvalid) break;
      check("rdata", s_axi_rdata, ref_mem[(beat_addr(addr, len, size, burst, i) >> 2) & 255]);
      check("rlast", s_axi_rlast, (i == len));
      check("rid", s_axi_rid, id);
      check("rresp", s_axi_rresp, 2'b00);
      case (mode)
        0:       r = 1'b1;
        1:       r = (cyc % 3 == 0);
        default: r = 1'($urandom_range(0, 1));
      endcase
      s_axi_rready = r;
      tick();
      if (r) i++;
      cyc++;
    end
    s_axi_rready = 1'b0;
    check("beats_done", i, len + 1);
    check("rvalid_end", s_axi_rvalid, 1'b0);
    check("rlast_end", s_axi_rlast, 1'b0);
    check("arready_end", s_axi_arready, 1'b1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned len, size, addr;
    logic [1:0] burst;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_awready", s_axi_awready, 1'b1);
    check("rst_arready", s_axi_arready, 1'b1);
    check("rst_wready", s_axi_wready, 1'b0);
    check("rst_bvalid", s_axi_bvalid, 1'b0);
    check("rst_rvalid", s_axi_rvalid, 1'b0);
    check("rst_rlast", s_axi_rlast, 1'b0);
    check("rst_bid", s_axi_bid, 8'h00);
    check("rst_rid", s_axi_rid, 8'h00);
    check("rst_rdata", s_axi_rdata, 32'h0);
    check("rst_resp", {s_axi_bresp, s_axi_rresp}, 4'h0);
    rst = 1'b0;
    tick();

    // Fill the modelled region with a maximum-length (256-beat) INCR burst
    for (int i = 0; i < 256; i++) begin wbuf[i] = $urandom; sbuf[i] = 4'hF; end
    do_write(0, 255, 2, 2'b01, 8'h01, 0, 1'b0);
    do_read(0, 255, 2, 2'b01, 8'h02, 0);

    // Single write / single read
    wbuf[0] = 32'hDEADBEEF; sbuf[0] = 4'hF;
    do_write(32'h10, 0, 2, 2'b01, 8'h5A, 0, 1'b0);
    do_read(32'h10, 0, 2, 2'b01, 8'h3C, 0);

    // INCR burst of 1..4
    for (int i = 0; i < 4; i++) begin wbuf[i] = 32'(i + 1); sbuf[i] = 4'hF; end
    do_write(32'h100, 3, 2, 2'b01, 8'h11, 0, 1'b0);
    do_read(32'h100, 3, 2, 2'b01, 8'h22, 0);

    // Byte strobes
    wbuf[0] = 32'h11223344; sbuf[0] = 4'hF;
    do_write(32'h20, 0, 2, 2'b01, 8'h01, 0, 1'b0);
    wbuf[0] = 32'hAABBCCDD; sbuf[0] = 4'h5;
    do_write(32'h20, 0, 2, 2'b01, 8'h02, 0, 1'b0);
    do_read(32'h20, 0, 2, 2'b01, 8'h03, 0);

    // Backpressure on R and B
    do_read(32'h100, 3, 2, 2'b01, 8'h44, 1);
    wbuf[0] = 32'hCAFEF00D; sbuf[0] = 4'hF;
    do_write(32'h30, 0, 2, 2'b01, 8'h77, 5, 1'b0);

    // FIXED burst: last beat wins
    for (int i = 0; i < 3; i++) begin wbuf[i] = 32'(i + 7); sbuf[i] = 4'hF; end
    do_write(32'h40, 2, 2, 2'b00, 8'h09, 0, 1'b0);
    do_read(32'h40, 0, 2, 2'b01, 8'h0A, 0);
    do_read(32'h40, 2, 2, 2'b00, 8'h0B, 2);

    // Reset after 2 of 4 W beats
    s_axi_awid = 8'h66; s_axi_awaddr = 16'h200; s_axi_awlen = 8'd3;
    s_axi_awsize = 3'd2; s_axi_awburst = 2'b01; s_axi_awvalid = 1'b1;
    tick();
    s_axi_awvalid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      s_axi_wdata = 32'hA000_0000 + 32'(i); s_axi_wstrb = 4'hF; s_axi_wvalid = 1'b1;
      tick();
      model_write(32'h200 + 4 * i, 32'hA000_0000 + 32'(i), 4'hF);
    end
    s_axi_wvalid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_awready", s_axi_awready, 1'b1);
    check("midrst_wready", s_axi_wready, 1'b0);
    check("midrst_bvalid", s_axi_bvalid, 1'b0);
    do_read(32'h200, 3, 2, 2'b01, 8'h67, 0);

    // Randomized bursts
    for (int n = 0; n < 60; n++) begin
      len   = $urandom_range(0, 15);
      size  = $urandom_range(0, 2);
      burst = 2'($urandom_range(0, 3));
      addr  = $urandom_range(0, 32'h400 - (len + 1) * (1 << size));
      if ($urandom_range(0, 1) == 1) begin
        for (int i = 0; i <= 15; i++) begin wbuf[i] = $urandom; sbuf[i] = 4'($urandom); end
        do_write(addr, len, size, burst, 8'($urandom), $urandom_range(0, 3), 1'b1);
      end else begin
        do_read(addr, len, size, burst, 8'($urandom), $urandom_range(0, 2));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/axi_burst_ram.md
Name: axi_burst_ram

Overview:
- AXI4 slave wrapping a byte-addressable, word-organised RAM.
- Serves as the backing memory for cache and interconnect simulation.
- Independent write (AW/W/B) and read (AR/R) engines run concurrently.
- Supports INCR and FIXED bursts up to 2^LEN_WIDTH beats; responses are always OKAY.

Parameters:
- DATA_WIDTH, 32: data bus width in bits; power of two, ≥8.
- ADDR_WIDTH, 16: byte address width; depth = 2^(ADDR_WIDTH-log2(STRB_WIDTH)) words.
- STRB_WIDTH, DATA_WIDTH/8: byte strobe width.
- ID_WIDTH, 8: transaction ID width.
- LEN_WIDTH, 8: burst length field width (beats = len+1).

Ports:
- clk in 1: clock, all logic on rising edge.
- rst in 1: synchronous, active-high reset.
- s_axi_awid in ID_WIDTH, s_axi_awaddr in ADDR_WIDTH, s_axi_awlen in LEN_WIDTH, s_axi_awsize in 3, s_axi_awburst in 2: write address channel.
- s_axi_awlock in 1, s_axi_awcache in 4, s_axi_awprot in 3, s_axi_awqos in 4: accepted, ignored.
- s_axi_awvalid in 1 / s_axi_awready out 1: AW handshake.
- s_axi_wdata in DATA_WIDTH, s_axi_wstrb in STRB_WIDTH, s_axi_wlast in 1 (ignored), s_axi_wvalid in 1 / s_axi_wready out 1: write data channel.
- s_axi_bid out ID_WIDTH, s_axi_bresp out 2, s_axi_bvalid out 1 / s_axi_bready in 1: write response channel.
- s_axi_arid, s_axi_araddr, s_axi_arlen, s_axi_arsize, s_axi_arburst, s_axi_arlock, s_axi_arcache, s_axi_arprot, s_axi_arqos: read address channel, same widths and meanings as the AW equivalents.
- s_axi_arvalid in 1 / s_axi_arready out 1: AR handshake.
- s_axi_rid out ID_WIDTH, s_axi_rdata out DATA_WIDTH, s_axi_rresp out 2, s_axi_rlast out 1, s_axi_rvalid out 1 / s_axi_rready in 1: read data channel.

Behaviour:
- One clock domain (clk). Reset is synchronous and active-high (rst).
- Reset values:
  - awready=1, arready=1.
  - wready, bvalid, rvalid, rlast = 0.
  - bid, rid, rdata = 0; bresp, rresp = 2'b00.
  - Both FSMs return to IDLE; memory contents are not cleared.
  - Reset mid-burst abandons the burst; bytes already written stay written.
- Word index = addr[ADDR_WIDTH-1:log2(STRB_WIDTH)]. Low address bits are ignored for array indexing. Out-of-range addresses cannot occur (full decode).
- Write FSM: W_IDLE -> W_BURST -> W_RESP -> W_IDLE.
  - W_IDLE: awready=1. On awvalid&awready, latch id, addr, len, size and burst; wready=1 next cycle.
  - W_BURST: wready=1. Each wvalid&wready beat writes byte i iff wstrb[i].
    - INCR: address += 2^size after each beat.
    - FIXED: address held.
    - Beat counter decrements; on the len+1-th beat, wready=0 and bvalid=1 next cycle.
    - wlast is not checked; beat count governs.
  - W_RESP: bvalid=1, bid=latched id, bresp=OKAY. On bready, bvalid=0 and awready=1 next cycle.
  - AW is not accepted while a burst or response is pending.
- Read FSM: R_IDLE -> R_BURST -> R_IDLE.
  - R_IDLE: arready=1. On arvalid&arready, latch id, addr, len, size, burst.
  - R_BURST: first beat rvalid=1 exactly one cycle after AR handshake. rdata is a registered read of the current address; rid=latched id; rresp=OKAY; rlast=1 on the final beat only.
  - rvalid&rready advances the address (INCR/FIXED as for writes) and presents the next beat the following cycle. Back-to-back beats every cycle while rready=1.
  - rvalid and rdata are held stable while rready=0.
  - After the last beat is accepted: rvalid=0, rlast=0, arready=1.
- Simultaneous read and write to the same word in the same cycle: read returns old data.
- awburst/arburst = WRAP(2'b10): see Optional Feature. Reserved(2'b11) is treated as INCR.

Optional Feature:
- Macro AXI_BURST_RAM_WRAP_EN.
- Defined: WRAP bursts wrap the address within an aligned block of (len+1)*2^size bytes. len must be 1, 3, 7 or 15; other values are treated as INCR.
- Undefined: WRAP is treated as INCR.

Decomposition:
- Package axi_burst_ram_pkg holds:
  - burst encodings FIXED=2'b00, INCR=2'b01, WRAP=2'b10;
  - RESP_OKAY=2'b00;
  - write and read FSM state encodings;
  - the address-advance function (address, size, burst, len).
- Sub-module axi_burst_ram_mem: simple dual-port RAM, one byte-enabled write port and one registered read port, parameterised by DATA_WIDTH and word-address width.

Test Plan:
- Single write: awaddr=0x10, awlen=0, wdata=0xDEADBEEF, wstrb=0xF -> bvalid one cycle after W beat, bid=awid, bresp=0. Then read of 0x10, arlen=0 -> rdata=0xDEADBEEF, rlast=1, rvalid one cycle after AR.
- INCR burst: awaddr=0x100, awlen=3, data 1..4 -> read awaddr=0x100, arlen=3 with rready=1 -> rdata 1,2,3,4 on consecutive cycles, rlast on 4th only, rid matches arid.
- Byte strobe: write 0x11223344 to 0x20, then 0xAABBCCDD with wstrb=0x5 -> read returns 0x11BB33DD.
- Backpressure: 4-beat read with rready toggling 1,0,0,1,... -> no beat lost or duplicated; rdata stable while stalled. Hold bready=0 five cycles -> bvalid held, awready=0.
- FIXED burst: awburst=0, awlen=2 to 0x40, data 7,8,9 -> single read of 0x40 returns 9.
- Reset mid-burst: assert rst after 2 of 4 W beats -> next cycle awready=1, wready=0, bvalid=0. Words 0 and 1 of the burst hold the written data.
